// File: rtl/fir_seq_ctrl.sv
// Sequencer for a single-MAC FIR: writes samples into a ring BRAM, walks taps, drives pipeline controls.
// Optional FIR_SEQ_CTRL_TLAST_CHECK_EN adds a sticky tlast_err flag for ss_tlast misplacement.
module fir_seq_ctrl #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
`ifdef FIR_SEQ_CTRL_TLAST_CHECK_EN
  output logic                   tlast_err,
`endif
  output logic                   Data_control,
  output logic                   Tape_control,
  output logic                   adder_rst_control,
  output logic                   output_control,
  output logic                   cal_rst_n
);

  localparam int unsigned KW = $clog2(Tape_Num + 1);

  typedef enum logic [2:0] {IDLE, WAIT_X, CLR, MAC, DRAIN, OUT} state_e;

  state_e        r_state, w_state_nx;
  logic [KW-1:0] r_wptr, w_wptr_nx;
  logic [KW-1:0] r_newest, w_newest_nx;
  logic [KW-1:0] r_k, w_k_nx;
  logic [KW-1:0] r_n_rx, w_n_rx_nx;
  logic [1:0]    r_drn, w_drn_nx;
  logic [31:0]   r_out_cnt, w_out_cnt_nx;
  logic [31:0]   r_len, w_len_nx;
  logic          r_ap_done, w_ap_done_nx;
  logic          r_data_ctl, w_data_ctl_nx;
  logic          r_tape_ctl, w_tape_ctl_nx;
  logic          r_cal_rst_n;
  logic          w_in_hs;
  logic          w_last_out;
  logic [KW-1:0] w_rd_idx;

  // Modular wrap of the intermediate sum is harmless: the true result is < Tape_Num.
  assign w_rd_idx   = (r_newest >= r_k) ? (r_newest - r_k) : (r_newest + KW'(Tape_Num) - r_k);
  assign w_last_out = (r_out_cnt == r_len - 32'd1);

  always_comb begin
    w_state_nx        = r_state;
    w_wptr_nx         = r_wptr;
    w_newest_nx       = r_newest;
    w_k_nx            = r_k;
    w_n_rx_nx         = r_n_rx;
    w_drn_nx          = r_drn;
    w_out_cnt_nx      = r_out_cnt;
    w_len_nx          = r_len;
    w_ap_done_nx      = 1'b0;
    w_in_hs           = 1'b0;
    ss_tready         = 1'b0;
    sm_tvalid         = 1'b0;
    sm_tlast          = 1'b0;
    data_WE           = 4'h0;
    data_A            = '0;
    data_Di           = '0;
    tap_A             = '0;
    adder_rst_control = 1'b1;
    output_control    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (ap_start) begin
          w_len_nx     = data_length;
          w_wptr_nx    = '0;
          w_k_nx       = '0;
          w_n_rx_nx    = '0;
          w_out_cnt_nx = '0;
          if (data_length == 32'd0) w_ap_done_nx = 1'b1;
          else                      w_state_nx   = WAIT_X;
        end
      end
      WAIT_X: begin
        ss_tready = 1'b1;
        data_A    = pADDR_WIDTH'({r_wptr, 2'b00});
        data_Di   = ss_tdata;
        if (ss_tvalid) begin
          w_in_hs     = 1'b1;
          data_WE     = 4'hF;
          w_newest_nx = r_wptr;
          w_wptr_nx   = (r_wptr == KW'(Tape_Num - 1)) ? '0 : r_wptr + 1'b1;
          if (r_n_rx < KW'(Tape_Num)) w_n_rx_nx = r_n_rx + 1'b1;
          w_state_nx  = CLR;
        end
      end
      CLR: begin
        w_k_nx     = '0;
        w_state_nx = MAC;
      end
      MAC: begin
        adder_rst_control = 1'b0;
        tap_A             = pADDR_WIDTH'({r_k, 2'b00});
        data_A            = pADDR_WIDTH'({w_rd_idx, 2'b00});
        if (r_k == KW'(Tape_Num - 1)) begin
          w_k_nx     = '0;
          w_drn_nx   = '0;
          w_state_nx = DRAIN;
        end else begin
          w_k_nx = r_k + 1'b1;
        end
      end
      DRAIN: begin
        adder_rst_control = 1'b0;
        if (r_drn == 2'd2) begin
          w_drn_nx   = '0;
          w_state_nx = OUT;
        end else begin
          w_drn_nx = r_drn + 1'b1;
        end
      end
      OUT: begin
        adder_rst_control = 1'b0;
        output_control    = 1'b1;
        sm_tvalid         = 1'b1;
        sm_tlast          = w_last_out;
        if (sm_tready) begin
          w_out_cnt_nx = r_out_cnt + 32'd1;
          if (w_last_out) begin
            w_ap_done_nx = 1'b1;
            w_state_nx   = IDLE;
          end else begin
            w_state_nx = WAIT_X;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // BRAM read data lands one cycle after the address, so the gating is registered.
    if (r_state == MAC) begin
      w_data_ctl_nx = (r_k >= r_n_rx);
      w_tape_ctl_nx = 1'b0;
    end else begin
      w_data_ctl_nx = 1'b1;
      w_tape_ctl_nx = 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_newest    <= '0;
      r_k         <= '0;
      r_n_rx      <= '0;
      r_drn       <= '0;
      r_out_cnt   <= '0;
      r_len       <= '0;
      r_ap_done   <= 1'b0;
      r_data_ctl  <= 1'b1;
      r_tape_ctl  <= 1'b1;
      r_cal_rst_n <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_wptr      <= w_wptr_nx;
      r_newest    <= w_newest_nx;
      r_k         <= w_k_nx;
      r_n_rx      <= w_n_rx_nx;
      r_drn       <= w_drn_nx;
      r_out_cnt   <= w_out_cnt_nx;
      r_len       <= w_len_nx;
      r_ap_done   <= w_ap_done_nx;
      r_data_ctl  <= w_data_ctl_nx;
      r_tape_ctl  <= w_tape_ctl_nx;
      r_cal_rst_n <= (w_state_nx != CLR);
    end
  end

  assign ap_idle      = (r_state == IDLE);
  assign ap_done      = r_ap_done;
  assign Data_control = r_data_ctl;
  assign Tape_control = r_tape_ctl;
  assign cal_rst_n    = r_cal_rst_n;

`ifdef FIR_SEQ_CTRL_TLAST_CHECK_EN
  logic r_tlast_err;

  // Sample index equals out_cnt while waiting for input: one output per input.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_tlast_err <= 1'b0;
    end else if (r_state == IDLE && ap_start) begin
      r_tlast_err <= 1'b0;
    end else if (w_in_hs && (ss_tlast != w_last_out)) begin
      r_tlast_err <= 1'b1;
    end
  end

  assign tlast_err = r_tlast_err;
`else
  logic w_unused_tlast;
  assign w_unused_tlast = ss_tlast ^ w_in_hs;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: models BRAMs and the MAC pipeline, scoreboards FIR outputs against a reference.
module tb_fir_seq_ctrl;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NT = 11;

  logic          clk, rst_n, ap_start;
  logic [31:0]   data_length;
  logic          ap_idle, ap_done;
  logic          ss_tvalid, ss_tlast, ss_tready;
  logic [DW-1:0] ss_tdata;
  logic          sm_tvalid, sm_tready, sm_tlast;
  logic [3:0]    data_WE;
  logic [AW-1:0] data_A, tap_A;
  logic [DW-1:0] data_Di;
  logic          Data_control, Tape_control, adder_rst_control, output_control, cal_rst_n;
`ifdef FIR_SEQ_CTRL_TLAST_CHECK_EN
  logic          tlast_err;
`endif

  fir_seq_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n), .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di), .tap_A(tap_A),
`ifdef FIR_SEQ_CTRL_TLAST_CHECK_EN
    .tlast_err(tlast_err),
`endif
    .Data_control(Data_control), .Tape_control(Tape_control),
    .adder_rst_control(adder_rst_control), .output_control(output_control),
    .cal_rst_n(cal_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] taps [NT];
  int          x_vec[$];
  logic [31:0] sb_y[$];
  logic        sb_last[$];

  // Pipeline model: 1-cycle BRAMs, D/T regs, multiplier reg, accumulator.
  logic [31:0] dmem [16];
  logic [31:0] d_do, t_do, d_reg, t_reg, m_reg, add_reg;
  wire  [31:0] y_out = output_control ? add_reg : 32'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'hDEAD_0000 | 32'(i);
    end else if (data_WE == 4'hF) begin
      dmem[data_A[5:2]] <= data_Di;
    end
    d_do <= dmem[data_A[5:2]];
    t_do <= (tap_A[5:2] < 4'(NT)) ? taps[tap_A[5:2]] : 32'hBAD0_BAD0;
    if (!cal_rst_n) begin
      d_reg <= '0;
      t_reg <= '0;
      m_reg <= '0;
    end else begin
      d_reg <= Data_control ? 32'd0 : d_do;
      t_reg <= Tape_control ? 32'd0 : t_do;
      m_reg <= d_reg * t_reg;
    end
    add_reg <= adder_rst_control ? 32'd0 : add_reg + m_reg;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic run_job(input int len, input int bp_at, input int ign_at, input int tl_at);
    int          cyc;
    logic [31:0] acc, exp_y, y_hold;
    logic        exp_last;
    sb_y.delete();
    sb_last.delete();
    sm_tready   = 1'b1;
    data_length = 32'(len);
    ap_start    = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    for (int n = 0; n < len; n++) begin
      acc = 32'd0;
      for (int k = 0; k < NT; k++) if (n - k >= 0) acc += taps[k] * 32'(x_vec[n-k]);
      sb_y.push_back(acc);
      sb_last.push_back(n == len - 1);
      ss_tdata  = 32'(x_vec[n]);
      ss_tlast  = (n == tl_at);
      ss_tvalid = 1'b1;
      #1;
      cyc = 0;
      while (!ss_tready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (!ss_tready) begin
        failures++;
        $display("FAIL in_handshake n=%0d: ss_tready=%b required 1 within 50 cycles", n, ss_tready);
        ss_tvalid = 1'b0;
        return;
      end
      checks++;
      if (data_WE !== 4'hF || data_A !== AW'(4 * (n % NT))) begin
        failures++;
        $display("FAIL write n=%0d: WE=%h A=%0d required WE=f A=%0d", n, data_WE, data_A,
                 4 * (n % NT));
      end
      @(negedge clk);
      ss_tvalid = 1'b0;
      cyc = 1;
      while (!sm_tvalid && cyc < 100) begin
        ap_start = (n == ign_at && cyc == 4);
        @(negedge clk);
        cyc++;
      end
      ap_start = 1'b0;
      checks++;
      if (cyc != 16) begin
        failures++;
        $display("FAIL latency n=%0d: got %0d cycles required 16", n, cyc);
      end
      if (!sm_tvalid) return;
      if (n == bp_at) begin
        sm_tready = 1'b0;
        y_hold    = y_out;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checks++;
          if (sm_tvalid !== 1'b1 || output_control !== 1'b1 || y_out !== y_hold) begin
            failures++;
            $display("FAIL backpressure i=%0d: tvalid=%b oc=%b y=%0d required 1 1 %0d", i,
                     sm_tvalid, output_control, y_out, y_hold);
          end
        end
        sm_tready = 1'b1;
      end
      exp_y    = sb_y.pop_front();
      exp_last = sb_last.pop_front();
      checks++;
      if (y_out !== exp_y) begin
        failures++;
        $display("FAIL y n=%0d: got %0d required %0d", n, y_out, exp_y);
      end
      checks++;
      if (sm_tlast !== exp_last) begin
        failures++;
        $display("FAIL tlast n=%0d: got %b required %b", n, sm_tlast, exp_last);
      end
      @(negedge clk);
      checks++;
      if (ap_done !== exp_last) begin
        failures++;
        $display("FAIL ap_done n=%0d: got %b required %b", n, ap_done, exp_last);
      end
    end
    @(negedge clk);
    checks++;
    if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse: ap_done=%b ap_idle=%b required 0 1", ap_done, ap_idle);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ap_idle, ap_done, ss_tready, sm_tvalid, sm_tlast} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_status: got %b required 10000",
               {ap_idle, ap_done, ss_tready, sm_tvalid, sm_tlast});
    end
    checks++;
    if (data_WE !== 4'h0 || data_A !== '0 || tap_A !== '0 || data_Di !== '0) begin
      failures++;
      $display("FAIL reset_bram: WE=%h A=%0d tapA=%0d Di=%0d required all 0", data_WE, data_A,
               tap_A, data_Di);
    end
    checks++;
    if ({Data_control, Tape_control, adder_rst_control, output_control, cal_rst_n} !== 5'b11100)
    begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 11100",
               {Data_control, Tape_control, adder_rst_control, output_control, cal_rst_n});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cal_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL cal_rst_hold: got %b required 0", cal_rst_n);
    end
    @(negedge clk);
    checks++;
    if (cal_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL cal_rst_rise: got %b required 1", cal_rst_n);
    end
  endtask

  task automatic test_zero_len();
    data_length = 32'd0;
    ap_start    = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    checks++;
    if (ap_done !== 1'b1 || ap_idle !== 1'b1 || ss_tready !== 1'b0) begin
      failures++;
      $display("FAIL zero_len: done=%b idle=%b tready=%b required 1 1 0", ap_done, ap_idle,
               ss_tready);
    end
    @(negedge clk);
    checks++;
    if (ap_done !== 1'b0 || ap_idle !== 1'b1 || sm_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_after: done=%b idle=%b tvalid=%b required 0 1 0", ap_done, ap_idle,
               sm_tvalid);
    end
  endtask

  task automatic test_ramp();
    for (int k = 0; k < NT; k++) taps[k] = 32'd1;
    x_vec = '{1, 2, 3, 4, 5};
    run_job(5, -1, -1, 4);
  endtask

  task automatic test_impulse();
    for (int k = 0; k < NT; k++) taps[k] = 32'(k + 1);
    x_vec.delete();
    for (int n = 0; n < 11; n++) x_vec.push_back(n == 0 ? 1 : 0);
    run_job(11, -1, -1, 10);
  endtask

  task automatic test_wrap_backpressure();
    for (int k = 0; k < NT; k++) taps[k] = 32'd1;
    x_vec.delete();
    for (int n = 1; n <= 13; n++) x_vec.push_back(n);
    run_job(13, 12, 6, 12);
  endtask

  task automatic test_reset_mid_mac();
    int cyc;
    for (int k = 0; k < NT; k++) taps[k] = 32'd1;
    data_length = 32'd4;
    ap_start    = 1'b1;
    @(negedge clk);
    ap_start  = 1'b0;
    ss_tdata  = 32'd7;
    ss_tlast  = 1'b0;
    ss_tvalid = 1'b1;
    @(negedge clk);
    ss_tvalid = 1'b0;
    cyc = 0;
    while (tap_A !== AW'(20) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (tap_A !== AW'(20)) begin
      failures++;
      $display("FAIL mid_mac_reach: tap_A=%0d required 20", tap_A);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ap_idle, ap_done, ss_tready, sm_tvalid, sm_tlast} !== 5'b10000 || data_WE !== 4'h0 ||
        data_A !== '0 || tap_A !== '0 || data_Di !== '0) begin
      failures++;
      $display("FAIL mid_mac_status: st=%b WE=%h A=%0d tapA=%0d required 10000 0 0 0",
               {ap_idle, ap_done, ss_tready, sm_tvalid, sm_tlast}, data_WE, data_A, tap_A);
    end
    @(negedge clk);
    checks++;
    if ({Data_control, Tape_control, adder_rst_control, output_control, cal_rst_n} !== 5'b11100)
    begin
      failures++;
      $display("FAIL mid_mac_ctrl: got %b required 11100",
               {Data_control, Tape_control, adder_rst_control, output_control, cal_rst_n});
    end
    rst_n = 1'b1;
    @(negedge clk);
    x_vec = '{1, 2, 3, 4, 5};
    run_job(5, -1, -1, 4);
  endtask

`ifdef FIR_SEQ_CTRL_TLAST_CHECK_EN
  task automatic test_tlast_err();
    for (int k = 0; k < NT; k++) taps[k] = 32'd1;
    x_vec.delete();
    for (int n = 1; n <= 11; n++) x_vec.push_back(n);
    run_job(11, -1, -1, 3);
    checks++;
    if (tlast_err !== 1'b1) begin
      failures++;
      $display("FAIL tlast_err_set: got %b required 1", tlast_err);
    end
    data_length = 32'd0;
    ap_start    = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    checks++;
    if (tlast_err !== 1'b0) begin
      failures++;
      $display("FAIL tlast_err_clear: got %b required 0", tlast_err);
    end
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    ap_start    = 1'b0;
    data_length = 32'd0;
    ss_tvalid   = 1'b0;
    ss_tdata    = '0;
    ss_tlast    = 1'b0;
    sm_tready   = 1'b0;
    for (int k = 0; k < NT; k++) taps[k] = 32'd0;
    test_reset();
    test_zero_len();
    test_ramp();
    test_impulse();
    test_wrap_backpressure();
    test_reset_mid_mac();
`ifdef FIR_SEQ_CTRL_TLAST_CHECK_EN
    test_tlast_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameters SHALL be: pADDR_WIDTH, default 12, BRAM address width; pDATA_WIDTH, default 32, data width; Tape_Num, default 11, number of FIR taps.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low: axis_clk  in  1  clock; axis_rst_n  in  1  asynchronous active-low reset.
REQ-003 ap_start  in  1  one-cycle start pulse; data_length  in  32  number of samples to process.
REQ-004 ap_idle  out  1  high in IDLE; ap_done  out  1  one-cycle pulse after the final output handshake.
REQ-005 ss_tvalid  in  1; ss_tdata  in  pDATA_WIDTH; ss_tlast  in  1; ss_tready  out  1 (input AXI-Stream).
REQ-006 sm_tvalid  out  1; sm_tready  in  1; sm_tlast  out  1 (output AXI-Stream; data comes from the pipeline y_output).
REQ-007 data_WE  out  4  byte write enable; data_A  out  pADDR_WIDTH  byte address; data_Di  out  pDATA_WIDTH  write data; tap_A  out  pADDR_WIDTH  tap byte address.
REQ-008 Pipeline controls SHALL be outputs, 1 bit each: Data_control (zero D_reg input), Tape_control (zero T_reg input), adder_rst_control, output_control, cal_rst_n (synchronous pipeline clear, active-low).

Function
REQ-009 FSM states SHALL be IDLE, WAIT_X, CLR, MAC, DRAIN, OUT.
REQ-010 IDLE -> WAIT_X on ap_start; wptr, k, n_rx and out_cnt are cleared.
REQ-011 WAIT_X: ss_tready=1. On ss_tvalid&ss_tready: data_WE=4'hF, data_A=4*wptr, data_Di=ss_tdata, n_rx=min(n_rx+1,Tape_Num), wptr wraps Tape_Num-1 -> 0; go to CLR.
REQ-012 CLR: exactly 1 cycle with cal_rst_n=0; go to MAC.
REQ-013 MAC: exactly Tape_Num cycles, k=0..Tape_Num-1, tap_A=4*k, data_A=4*((newest_ptr-k) mod Tape_Num), data_WE=0.
REQ-014 BRAM read latency SHALL be 1 cycle; Data_control and Tape_control are registered one cycle after address issue.
REQ-015 Data_control SHALL be 1 for a tap if k>=n_rx (unfilled ring slot) or if no MAC address was issued in the previous cycle; Tape_control SHALL be 1 only in the no-address case.
REQ-016 DRAIN: exactly 3 cycles, during which adder_rst_control=0; then go to OUT. The final sum is valid in Add_reg on the first OUT cycle.
REQ-017 OUT: output_control=1 and sm_tvalid=1 held until sm_tready; sm_tlast=1 when out_cnt==data_length-1.
REQ-018 On the OUT handshake, out_cnt increments. If out_cnt reaches data_length: pulse ap_done and go to IDLE; otherwise go to WAIT_X.
REQ-019 adder_rst_control SHALL be 1 in IDLE, WAIT_X and CLR, and 0 otherwise.
REQ-020 Latency from the input handshake to the first sm_tvalid SHALL be exactly 1+1+Tape_Num+3 cycles (16 at default).
REQ-021 sm_tvalid with sm_tready low SHALL hold state; output_control stays 1 so that y_output is stable.
REQ-022 data_length==0 with ap_start SHALL give ap_done on the next cycle and return to IDLE; no stream activity occurs.
REQ-023 ap_start outside IDLE SHALL be ignored.

Reset
REQ-024 On axis_rst_n=0 (any state, including mid-MAC): state=IDLE, all counters 0, ss_tready=0, sm_tvalid=0, sm_tlast=0, ap_done=0, ap_idle=1, data_WE=0, data_A=0, tap_A=0, data_Di=0, Data_control=1, Tape_control=1, adder_rst_control=1, output_control=0, cal_rst_n=0.
REQ-025 After reset release, cal_rst_n SHALL rise on the next clock edge.

Configuration
REQ-026 Macro FIR_SEQ_CTRL_TLAST_CHECK_EN. When defined: add output tlast_err (1 bit), sticky and cleared by ap_start, set if ss_tlast on an input handshake disagrees with (sample index==data_length-1).
REQ-027 When FIR_SEQ_CTRL_TLAST_CHECK_EN is not defined: no tlast_err port and ss_tlast is ignored.

Verification
REQ-028 Impulse: taps 1..11, data_length=11, x=1,0,0,... -> y=1,2,...,11, sm_tlast on the 11th output, then one ap_done.
REQ-029 Ramp before ring fill: taps all 1, x=1..5 -> y=1,3,6,10,15 (unfilled slots zeroed via Data_control).
REQ-030 Wrap-around: taps all 1, x=1..13 -> y[12]=sum(3..13)=88; wptr wraps after 10.
REQ-031 Backpressure: sm_tready held low 5 cycles during OUT -> sm_tvalid, y_output and output_control stable; no sample loss.
REQ-032 Reset mid-MAC: assert axis_rst_n=0 at MAC k=5 -> all REQ-024 values next cycle; a new ap_start run produces correct results.
REQ-033 With FIR_SEQ_CTRL_TLAST_CHECK_EN defined: ss_tlast on sample 3 of 11 -> tlast_err=1 until the next ap_start.
